bit_reverse_reorder: RTL and testbench



---
 rtl/bit_reverse_reorder.sv | 128 ++++++++++++
 tb/tb_bit_reverse_reorder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_reverse_reorder.sv
// Purpose : frame reorder buffer, natural index order in, bit-reversed index order out.
// Latency : first output is valid the cycle after the DEPTH-th input is accepted.
// Backpr. : out_ready=0 holds out_data/out_last/rd_cnt; a full write bank drops in_ready.
// Build option BITREV_PINGPONG_EN: two banks, so filling one overlaps draining the other.
module bit_reverse_reorder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef BITREV_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  // Bank pointers are one bit in both builds; with a single bank they stay 0.
  logic [DATA_WIDTH-1:0] mem [NBANK][DEPTH];
  logic [NBANK-1:0]      full;
  logic [NBANK-1:0]      full_nxt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [ADDR_BITS-1:0]  wr_cnt;
  logic [ADDR_BITS-1:0]  rd_cnt;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_wrap;
  logic                  rd_wrap;

  // Reverse all address bits: bit i moves to bit ADDR_BITS-1-i.
  function automatic logic [ADDR_BITS-1:0] rev(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] r;
    for (int i = 0; i < ADDR_BITS; i++) begin
      r[i] = a[ADDR_BITS-1-i];
    end
    return r;
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_wrap   = wr_fire && (wr_cnt == '1);
  assign rd_wrap   = rd_fire && (rd_cnt == '1);
  assign rd_addr   = rev(rd_cnt);
  assign out_last  = out_valid && (rd_cnt == '1);

  // Zero-latency read from registered pointers; output forced to 0 when idle.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = mem[rd_bank][rd_addr];
    end
  end

  // Next full flags: a completed drain and a completed fill always hit different banks.
  always_comb begin
    full_nxt = full;
    if (rd_wrap) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (wr_wrap) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Sample storage, written in natural order; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

  // Write side: count samples into the current bank, hand it to the reader on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_wrap) begin
`ifdef BITREV_PINGPONG_EN
        wr_bank <= ~wr_bank;
`else
        wr_bank <= 1'b0;
`endif
      end
    end
  end

  // Read side: step through the bank in bit-reversed order, release it on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_wrap) begin
`ifdef BITREV_PINGPONG_EN
        rd_bank <= ~rd_bank;
`else
        rd_bank <= 1'b0;
`endif
      end
    end
  end

  // Per-bank FILL/DRAIN state held as the full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder: ADDR_BITS=3 main instance plus an ADDR_BITS=1 instance.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Covers reset, order, backpressure, fill blocking or ping-pong streaming, mid-frame reset.
module tb_bit_reverse_reorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] in_data1;
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] out_data1;
  logic       out_valid1;
  logic       out_ready1;
  logic       out_last1;

  int n_vec = 0;
  int n_err = 0;
  int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [7:0] frame_dat [8];

  always #5 clk = ~clk;

  bit_reverse_reorder #(.DATA_WIDTH(8), .ADDR_BITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  bit_reverse_reorder #(.DATA_WIDTH(8), .ADDR_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write frame_dat[first..7] on consecutive cycles.
  task automatic write_frame(input int first);
    for (int i = first; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = frame_dat[i];
      @(negedge clk);
      check($sformatf("wr_rdy[%0d]", i), in_ready, 1);
      check($sformatf("wr_oval[%0d]", i), out_valid, 0);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  // Drain one frame, optionally stalling stall_len cycles at output stall_at.
  task automatic drain_frame(input int stall_at, input int stall_len, input bit blocked);
    int k = 0;
    int stalls = stall_len;
    while (k < 8) begin
      out_ready = !(k == stall_at && stalls > 0);
      @(negedge clk);
      check($sformatf("rd_val[%0d]", k), out_valid, 1);
      check($sformatf("rd_dat[%0d]", k), out_data, frame_dat[rev3[k]]);
      check($sformatf("rd_last[%0d]", k), out_last, (k == 7));
      if (blocked) check($sformatf("blk_rdy[%0d]", k), in_ready, 0);
      next_cycle();
      if (out_ready) k++;
      else stalls--;
    end
    @(negedge clk);
    check("drained_val", out_valid, 0);
    check("drained_dat", out_data, 0);
    if (blocked) check("unblk_rdy", in_ready, 1);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    next_cycle();
    rst_n = 1'b1;

    // Basic order: 0..7 in, 0,4,2,6,1,5,3,7 out.
    for (int i = 0; i < 8; i++) frame_dat[i] = 8'(i);
    out_ready = 1'b1;
    write_frame(0);
    drain_frame(-1, 0, 1'b0);

    // Backpressure: 3-cycle stall on the third output.
    write_frame(0);
    drain_frame(2, 3, 1'b0);

`ifdef BITREV_PINGPONG_EN
    // Ping-pong: 0..15 back to back, continuous output.
    out_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      in_valid = (t < 16);
      in_data  = 8'(t);
      @(negedge clk);
      if (t < 16) check($sformatf("pp_rdy[%0d]", t), in_ready, 1);
      if (t < 8) begin
        check($sformatf("pp_oval[%0d]", t), out_valid, 0);
      end else begin
        check($sformatf("pp_val[%0d]", t), out_valid, 1);
        check($sformatf("pp_dat[%0d]", t), out_data,
              (t < 16) ? rev3[t-8] : 8 + rev3[t-16]);
        check($sformatf("pp_last[%0d]", t), out_last, (t == 15 || t == 23));
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_end_val", out_valid, 0);
    next_cycle();
`else
    // Fill blocking: 0xAA offered during drain becomes index 0 of the next frame.
    for (int i = 0; i < 8; i++) frame_dat[i] = 8'(8'h20 + i);
    write_frame(0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    drain_frame(-1, 0, 1'b1);
    frame_dat[0] = 8'hAA;
    for (int i = 1; i < 8; i++) frame_dat[i] = 8'(8'h30 + i);
    write_frame(1);
    drain_frame(-1, 0, 1'b0);
`endif

    // Mid-frame reset discards the partial frame.
    frame_dat[0] = 8'h11; frame_dat[1] = 8'h22; frame_dat[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = frame_dat[i];
      next_cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_in_ready", in_ready, 1);
    check("mr_out_valid", out_valid, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) frame_dat[i] = 8'(8 + i);
    write_frame(0);
    drain_frame(-1, 0, 1'b0);

    // ADDR_BITS=1: identity order.
    in_valid1 = 1'b1;
    in_data1  = 8'd5;
    @(negedge clk);
    check("d1_rdy0", in_ready1, 1);
    next_cycle();
    in_data1 = 8'd9;
    @(negedge clk);
    check("d1_rdy1", in_ready1, 1);
    check("d1_oval", out_valid1, 0);
    next_cycle();
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(negedge clk);
    check("d1_val0", out_valid1, 1);
    check("d1_dat0", out_data1, 5);
    check("d1_last0", out_last1, 0);
    next_cycle();
    @(negedge clk);
    check("d1_val1", out_valid1, 1);
    check("d1_dat1", out_data1, 9);
    check("d1_last1", out_last1, 1);
    next_cycle();
    @(negedge clk);
    check("d1_end", out_valid1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
